// File: rtl/median3x3_stream.sv
// 3x3 rank filter (median / min / max / bypass) with its own two line buffers and border handling.
// Latency: fixed 3 pclk cycles from the de_in sample edge to data_out/de_out/vs_out, in every mode.
// No back-pressure: one pixel per clock sustained; de_in gaps simply hold position and window state.
module median3x3_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode,
  output logic              vs_out,
  output logic              de_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_MEDIAN = 2'b01;
  localparam logic [1:0] MODE_MIN    = 2'b10;
  localparam logic [1:0] MODE_MAX    = 2'b11;

  typedef logic [DATA_W-1:0] px_t;

  function automatic px_t max2(input px_t a, input px_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic px_t min2(input px_t a, input px_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic px_t max3(input px_t a, input px_t b, input px_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic px_t min3(input px_t a, input px_t b, input px_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic px_t med3(input px_t a, input px_t b, input px_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    mode_q;

  px_t lb0 [IMG_W];
  px_t lb1 [IMG_W];
  px_t lb0_rd, lb1_rd;

  // live[0] = row r-2, live[1] = row r-1, live[2] = row r (current pixel column)
  px_t live [3];
  // win[i][0] holds column c-1, win[i][1] holds column c-2
  px_t win [3][2];
  logic border;

  px_t        s1_max [3];
  px_t        s1_med [3];
  px_t        s1_min [3];
  px_t        s1_pix;
  logic       s1_bord;
  logic [1:0] s1_mode;
  logic       s1_de, s1_vs;

  px_t        s2_mom, s2_mem, s2_xom, s2_min9, s2_max9, s2_pix;
  logic       s2_bord;
  logic [1:0] s2_mode;
  logic       s2_de, s2_vs;

  px_t median, sel_dat;

  assign lb0_rd  = lb0[col];
  assign lb1_rd  = lb1[col];
  assign live[0] = lb1_rd;
  assign live[1] = lb0_rd;
  assign live[2] = data_in;
  assign border  = (row < RW'(2)) || (col < CW'(2));

  // Position tracking: column wraps per line, row saturates, frame start clears and latches mode
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      mode_q <= MODE_MEDIAN;
    end else if (vs_in) begin
      col    <= '0;
      row    <= '0;
      mode_q <= mode;
    end else if (de_in) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        if (row != RW'(IMG_H - 1)) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers: read-before-write, lb0 cascades into lb1; contents are never cleared
  always_ff @(posedge pclk) begin
    if (de_in) begin
      lb0[col] <= data_in;
      lb1[col] <= lb0_rd;
    end
  end

  // Window shift: the live column moves into c-1, c-1 moves into c-2
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= '0;
        win[i][1] <= '0;
      end
    end else if (de_in) begin
      for (int i = 0; i < 3; i++) begin
        win[i][1] <= win[i][0];
        win[i][0] <= live[i];
      end
    end
  end

  // Stage 1: sort each window row; pixel, border flag and mode travel alongside
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        s1_max[i] <= '0;
        s1_med[i] <= '0;
        s1_min[i] <= '0;
      end
      s1_pix  <= '0;
      s1_bord <= 1'b0;
      s1_mode <= '0;
      s1_de   <= 1'b0;
      s1_vs   <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        s1_max[i] <= max3(live[i], win[i][0], win[i][1]);
        s1_med[i] <= med3(live[i], win[i][0], win[i][1]);
        s1_min[i] <= min3(live[i], win[i][0], win[i][1]);
      end
      s1_pix  <= data_in;
      s1_bord <= border;
      s1_mode <= mode_q;
      s1_de   <= de_in;
      s1_vs   <= vs_in;
    end
  end

  // Stage 2: cross-row reduction to median candidates and global min/max
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s2_mom  <= '0;
      s2_mem  <= '0;
      s2_xom  <= '0;
      s2_min9 <= '0;
      s2_max9 <= '0;
      s2_pix  <= '0;
      s2_bord <= 1'b0;
      s2_mode <= '0;
      s2_de   <= 1'b0;
      s2_vs   <= 1'b0;
    end else begin
      s2_mom  <= min3(s1_max[0], s1_max[1], s1_max[2]);
      s2_mem  <= med3(s1_med[0], s1_med[1], s1_med[2]);
      s2_xom  <= max3(s1_min[0], s1_min[1], s1_min[2]);
      s2_min9 <= min3(s1_min[0], s1_min[1], s1_min[2]);
      s2_max9 <= max3(s1_max[0], s1_max[1], s1_max[2]);
      s2_pix  <= s1_pix;
      s2_bord <= s1_bord;
      s2_mode <= s1_mode;
      s2_de   <= s1_de;
      s2_vs   <= s1_vs;
    end
  end

  // Output select: border pixels and bypass mode echo the delay-matched input pixel
  always_comb begin
    median  = med3(s2_mom, s2_mem, s2_xom);
    sel_dat = s2_pix;
    if (!s2_bord) begin
      case (s2_mode)
        MODE_BYPASS: sel_dat = s2_pix;
        MODE_MEDIAN: sel_dat = median;
        MODE_MIN:    sel_dat = s2_min9;
        MODE_MAX:    sel_dat = s2_max9;
        default:     sel_dat = s2_pix;
      endcase
    end
  end

  // Stage 3: output registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      de_out   <= 1'b0;
      vs_out   <= 1'b0;
    end else begin
      data_out <= sel_dat;
      de_out   <= s2_de;
      vs_out   <= s2_vs;
    end
  end

endmodule

// File: tb/tb_median3x3_stream.sv
// Randomized bench for median3x3_stream on a small 8x6 image.
// Expected pixels come from a whole-frame reference (sort of the 3x3 neighbourhood) pushed into a queue.
// A negedge monitor pops the queue on every de_out and checks the 3-cycle de/vs delay every cycle.
module tb_median3x3_stream;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          pclk = 1'b0;
  logic          rst;
  logic          vs_in, de_in;
  logic [DW-1:0] data_in;
  logic [1:0]    mode;
  logic          vs_out, de_out;
  logic [DW-1:0] data_out;

  always #5 pclk = ~pclk;

  median3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .pclk(pclk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .data_in(data_in),
    .mode(mode), .vs_out(vs_out), .de_out(de_out), .data_out(data_out)
  );

  int            checks = 0;
  int            passes = 0;
  int            de_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] frame [0:H-1][0:W-1];
  int            tr, tc;
  logic [1:0]    model_mode;
  bit            de_h [3];
  bit            vs_h [3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Reference: sort the nine neighbours of (r,c) in rows r-2..r, cols c-2..c
  function automatic int ref_px(input int r, input int c, input logic [1:0] m);
    int v [9];
    int t;
    if (m == 2'b00 || r < 2 || c < 2) return int'(frame[r][c]);
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v[dr*3+dc] = int'(frame[r-dr][c-dc]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    case (m)
      2'b01:   return v[4];
      2'b10:   return v[0];
      default: return v[8];
    endcase
  endfunction

  // Monitor: output checks on the falling edge, away from the DUT's active edge
  initial begin
    forever begin
      @(negedge pclk);
      if (rst) begin
        check("reset_out", int'({vs_out, de_out, data_out}), 0);
        for (int i = 0; i < 3; i++) begin de_h[i] = 1'b0; vs_h[i] = 1'b0; end
      end else begin
        check("de_vs_delay", int'({de_out, vs_out}), int'({de_h[2], vs_h[2]}));
        if (de_out) begin
          int have;
          de_cnt++;
          have = exp_q.size();
          check("out_expected", int'(have > 0), 1);
          if (have > 0) check("pixel", int'(data_out), int'(exp_q.pop_front()));
        end
        de_h[2] = de_h[1]; de_h[1] = de_h[0]; de_h[0] = de_in;
        vs_h[2] = vs_h[1]; vs_h[1] = vs_h[0]; vs_h[0] = vs_in;
      end
    end
  end

  task automatic slot();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    de_in = 1'b0;
    vs_in = 1'b0;
    repeat (n) slot();
  endtask

  task automatic frame_start(input logic [1:0] m);
    vs_in = 1'b1; de_in = 1'b0; mode = m;
    model_mode = m; tr = 0; tc = 0;
    slot();
    idle(1);
  endtask

  task automatic pix(input logic [DW-1:0] v);
    de_in = 1'b1; vs_in = 1'b0; data_in = v;
    frame[tr][tc] = v;
    exp_q.push_back(DW'(ref_px(tr, tc, model_mode)));
    if (tc == W - 1) begin
      tc = 0;
      if (tr < H - 1) tr++;
    end else begin
      tc++;
    end
    slot();
    de_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; de_in = 1'b0; vs_in = 1'b0;
    slot();
    exp_q.delete();
    model_mode = 2'b01; tr = 0; tc = 0;
    slot();
    rst = 1'b0;
    slot();
  endtask

  // pat: 0 const, 1 impulse, 2 ramp, 3 random; gap: 0 none, 1 every other cycle, 2 random
  task automatic run_frame(input int pat, input int gap, input logic [1:0] m, input bit with_vs,
                           input int switch_at, input int rst_row);
    int base;
    int n;
    logic [DW-1:0] v;
    n = 0;
    if (with_vs) frame_start(m);
    base = de_cnt;
    for (int p = 0; p < W * H; p++) begin
      if (rst_row >= 0 && tr == rst_row && tc == 0) begin
        do_reset();
        return;
      end
      if (p == switch_at) mode = 2'b11;
      case (pat)
        0:       v = 8'h40;
        1:       v = (tr == 3 && tc == 3) ? 8'hFF : 8'h10;
        2:       v = DW'(8 * tr + tc);
        default: v = DW'($urandom);
      endcase
      pix(v);
      n++;
      if (gap == 1) idle(1);
      else if (gap == 2) idle(int'($urandom_range(0, 2)));
    end
    idle(5);
    check("frame_de_count", de_cnt - base, n);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passes, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; vs_in = 1'b0; de_in = 1'b0; data_in = '0; mode = 2'b01;
    model_mode = 2'b01; tr = 0; tc = 0;
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    run_frame(0, 0, 2'b01, 1'b1, -1, -1);
    run_frame(1, 0, 2'b01, 1'b1, -1, -1);
    run_frame(1, 0, 2'b11, 1'b1, -1, -1);
    run_frame(1, 0, 2'b10, 1'b1, -1, -1);
    run_frame(2, 0, 2'b01, 1'b1, -1, -1);
    run_frame(2, 1, 2'b01, 1'b1, -1, -1);
    run_frame(2, 2, 2'b01, 1'b1, -1, -1);
    run_frame(3, 0, 2'b00, 1'b1, -1, -1);
    run_frame(3, 0, 2'b01, 1'b1, 20, -1);
    run_frame(3, 0, 2'b11, 1'b1, -1, -1);
    run_frame(2, 0, 2'b01, 1'b1, -1, 3);
    run_frame(2, 0, 2'b01, 1'b0, -1, -1);
    run_frame(3, 2, 2'b10, 1'b1, -1, -1);
    run_frame(3, 1, 2'b01, 1'b1, -1, -1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
